crc32_bitserial_engine: RTL
===========================

// Module: crc32_bitserial_engine
// PURPOSE
//  Bit-serial CRC-32 datapath behind the TinyQV CRC peripheral register wrapper.
//  Consumes bytes written to the wrapper's input-data register and updates a running 32-bit CRC.
//  Presents the finished value for the wrapper's read-only result register.
//  Processes one bit per clock to minimise area: 8 shift cycles per byte.
// PARAMETERS
//  POLY    32'h04C11DB7  generator polynomial, normal (MSB-first) form
//  INIT    32'hFFFFFFFF  value loaded into crc_reg on reset and on clear
//  XOROUT  32'hFFFFFFFF  final XOR mask, applied only when xorout_en=1
// PORTS
//  clk          in   1   project clock (64 MHz nominal)
//  rst_n        in   1   synchronous reset, active-high: asserted when 1, sampled on posedge clk
//  enable       in   1   engine enable; 0 = freeze all state, data_ready=0
//  clear        in   1   1-cycle strobe: crc_reg<=INIT, byte_count<=0, abort any byte in flight
//  reflect_in   in   1   1 = feed each byte LSB first; 0 = MSB first; sampled at byte accept
//  reflect_out  in   1   1 = bit-reverse crc_reg before final XOR (combinational)
//  xorout_en    in   1   1 = XOR result with XOROUT (combinational)
//  data_in      in   8   byte to absorb
//  data_valid   in   1   data_in valid
//  data_ready   out  1   engine can accept a byte this cycle
//  crc_out      out  32  (reflect_out ? bitrev(crc_reg) : crc_reg) ^ (xorout_en ? XOROUT : 0)
//  busy         out  1   1 while in SHIFT
//  byte_done    out  1   1-cycle pulse after the 8th shift of a byte
//  byte_count   out  16  bytes absorbed since reset/clear; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-high.
//  - Reset (rst_n=1):
//      state=IDLE, crc_reg=INIT, bit_cnt=0, shift_byte=0, byte_count=0, byte_done=0.
//      Hence busy=0 and data_ready=enable after reset.
//  - States: IDLE, SHIFT.
//  - data_ready = (state==IDLE) & enable & ~clear. This is combinational.
//  - Accept: data_valid & data_ready at posedge E0.
//      Latch shift_byte = reflect_in ? data_in : bitrev8(data_in).
//      Set bit_cnt=0 and go to SHIFT.
//  - SHIFT, each enabled edge:
//      b = shift_byte[bit_cnt]
//      fb = crc_reg[31]^b
//      crc_reg = {crc_reg[30:0],1'b0} ^ (fb ? POLY : 0)
//      bit_cnt++
//  - At bit_cnt==7, on edge E8:
//      state -> IDLE, byte_count++, byte_done=1 for the following cycle.
//      data_ready returns in the cycle after E8, giving 9 cycles/byte max throughput.
//  - Latency: crc_out reflects the accepted byte from the cycle after E8 (same cycle as byte_done).
//  - enable=0 in SHIFT: bit_cnt, crc_reg and state hold; shifting resumes where it left off when enable=1.
//  - clear=1 (any state, regardless of enable):
//      crc_reg=INIT, byte_count=0, state=IDLE, byte_done=0.
//      A byte in flight is discarded and not counted.
//  - clear and data_valid in the same cycle: clear wins; the byte is not accepted (data_ready=0).
//  - rst_n has priority over clear; clear has priority over shift/accept.
//  - data_valid while busy: ignored, not queued. The wrapper must hold the byte until data_ready.
//  - reflect_in changes mid-byte: no effect on the byte in flight (latched at accept).
//  - reflect_out and xorout_en: purely combinational on crc_out; may change at any time.
//  - Empty message (clear only): crc_out = 32'h00000000 with reflect_out=1, xorout_en=1 and default parameters.
// TESTING
//  - Reset, then read outputs -> busy=0, byte_done=0, byte_count=0, data_ready=1, crc_out=32'h00000000 (refl_out=1, xor=1).
//  - CRC-32 (refl_in=1, refl_out=1, xor=1): clear, then "123456789" -> crc_out=32'hCBF43926, byte_count=9; each byte_done 9 cycles apart.
//  - CRC-32/BZIP2 (refl 0/0, xor=1): same string -> 32'hFC891918; toggle xorout_en=0 -> 32'h0376E6E7 (MPEG-2).
//  - Single byte 8'h61, CRC-32 settings -> 32'hE8B7BE43 exactly 9 cycles after accept; data_valid held while busy is not double-counted.
//  - Pull enable low 3 cycles mid-SHIFT -> result unchanged (32'hE8B7BE43), completion delayed 3 cycles.
//  - clear asserted in SHIFT bit 4, and clear+valid in the same cycle -> byte discarded, crc_out=0, byte_count=0, no byte_done.

Source files
------------

// File: rtl/crc32_bitserial_engine_if.sv
// Byte-stream and result bus between the TinyQV CRC register wrapper and
// the bit-serial CRC-32 engine.
//
// Handshake: a byte transfers on a rising clk edge where data_valid and
// data_ready are both 1. data_ready is combinational and may drop at any
// time. A byte presented while data_ready=0 is neither taken nor queued.
// The wrapper holds data_in and data_valid steady until the transfer occurs.
interface crc32_bitserial_engine_if;
  logic        enable;
  logic        clear;
  logic        reflect_in;
  logic        reflect_out;
  logic        xorout_en;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] crc_out;
  logic        busy;
  logic        byte_done;
  logic [15:0] byte_count;

  // Wrapper side: drives control and data, reads status and result.
  modport master (
    output enable, clear, reflect_in, reflect_out, xorout_en, data_in, data_valid,
    input  data_ready, crc_out, busy, byte_done, byte_count
  );

  // Engine side.
  modport slave (
    input  enable, clear, reflect_in, reflect_out, xorout_en, data_in, data_valid,
    output data_ready, crc_out, busy, byte_done, byte_count
  );
endinterface

// File: rtl/crc32_bitserial_engine.sv
// Bit-serial CRC-32 engine. It absorbs one accepted byte over 8 enabled
// clocks, one message bit per clock, through the normal-form (MSB-first) LFSR.
// Input bit order is fixed when the byte is accepted. Output reflection and
// the final XOR are applied combinationally on the result path.
module crc32_bitserial_engine #(
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,        // active-high synchronous reset
  crc32_bitserial_engine_if.slave  bus,
  output logic [0:0]               dbg_state_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_byte_q, shift_byte_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic        byte_done_q, byte_done_d;
  logic        fb;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The engine takes a byte only when idle, enabled, and not being cleared.
  assign bus.data_ready = (state_q == ST_IDLE) && bus.enable && !bus.clear;
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.byte_done  = byte_done_q;
  assign bus.byte_count = byte_count_q;
  assign bus.crc_out    = (bus.reflect_out ? bitrev32(crc_q) : crc_q)
                        ^ (bus.xorout_en ? XOROUT : 32'h0);
  assign dbg_state_o    = state_q;

  // Feedback bit for the current shift. bit 0 of shift_byte goes in first.
  assign fb = crc_q[31] ^ shift_byte_q[bit_cnt_q];

  // Next-state logic. Clear overrides everything. Disable freezes state.
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    bit_cnt_d    = bit_cnt_q;
    shift_byte_d = shift_byte_q;
    byte_count_d = byte_count_q;
    byte_done_d  = 1'b0;
    if (bus.clear) begin
      state_d      = ST_IDLE;
      crc_d        = INIT;
      bit_cnt_d    = 3'd0;
      byte_count_d = 16'd0;
    end else if (bus.enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.data_valid) begin
            // Store the byte so that its first-transmitted bit sits in bit 0.
            shift_byte_d = bus.reflect_in ? bus.data_in : bitrev8(bus.data_in);
            bit_cnt_d    = 3'd0;
            state_d      = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          crc_d     = {crc_q[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d      = ST_IDLE;
            byte_count_d = byte_count_q + 16'd1;
            byte_done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      crc_q        <= INIT;
      bit_cnt_q    <= 3'd0;
      shift_byte_q <= 8'd0;
      byte_count_q <= 16'd0;
      byte_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_byte_q <= shift_byte_d;
      byte_count_q <= byte_count_d;
      byte_done_q  <= byte_done_d;
    end
  end

endmodule
